// File: rtl/lsu_mem_initiator_pkg.sv
// lsu_mem_initiator_pkg: funct3 codes, FSM encoding and the registered request shared by the LSU files
package lsu_mem_initiator_pkg;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RMW_RD = 3'd2, S_WRITE = 3'd3, S_RESP = 3'd4;
  typedef struct packed {
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } req_t;
  function automatic logic [4:0] byte_lane(input logic [1:0] a);
    return {a, 3'b000};
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: request legality check, load lane extract/extend and sub-word store merge
module lsu_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [1:0]  i_req_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic        o_bad,
  output logic [31:0] o_ldata,
  output logic [31:0] o_merged
);
  logic        w_illegal, w_misal;
  logic [31:0] w_shift_r, w_mask;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  always_comb begin
    w_illegal = i_req_we ? (i_req_funct3 > F3_W) : (i_req_funct3 == 3'b011 || i_req_funct3[2:1] == 2'b11);
    w_misal   = (i_req_funct3[1:0] == 2'b01 && i_req_addr_lo[0]) ||
                (i_req_funct3[1:0] == 2'b10 && i_req_addr_lo != 2'b00);
    o_bad     = w_illegal | w_misal;
    // halves are always 2-byte aligned here, so the byte shift also selects the half lane
    w_shift_r = i_rdata >> byte_lane(i_addr_lo);
    w_byte    = w_shift_r[7:0];
    w_half    = w_shift_r[15:0];
    o_ldata   = i_funct3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                i_funct3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                i_funct3 == F3_BU ? {24'h0, w_byte} :
                i_funct3 == F3_HU ? {16'h0, w_half} : i_rdata;
    w_mask    = (i_funct3[1:0] == 2'b00 ? 32'h0000_00FF :
                 i_funct3[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << byte_lane(i_addr_lo);
    o_merged  = (i_old & ~w_mask) | ((i_wdata << byte_lane(i_addr_lo)) & w_mask);
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RV32I load/store FSM driving a word-addressed memory with read-modify-write for sub-word stores
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        en_w,
  output logic [31:0] data_mem_addr,
  output logic [31:0] data_mem_write,
  input  logic [31:0] data_mem_read
);
  logic [2:0]  r_state, w_next, w_acc_next;
  req_t        r_req;
  logic [31:0] r_old, r_rdata, r_mem_addr, w_widx, w_ldata, w_merged;
  logic        r_err, w_bad, w_err, w_accept;
  lsu_align u_align (
    .i_req_we      (req_we),
    .i_req_funct3  (req_funct3),
    .i_req_addr_lo (req_addr[1:0]),
    .i_funct3      (r_req.funct3),
    .i_addr_lo     (r_req.addr_lo),
    .i_rdata       (data_mem_read),
    .i_wdata       (r_req.wdata),
    .i_old         (r_old),
    .o_bad         (w_bad),
    .o_ldata       (w_ldata),
    .o_merged      (w_merged)
  );
  always_comb begin
    req_ready  = r_state == S_IDLE || r_state == S_RESP;
    w_accept   = req_valid & req_ready;
    w_widx     = {2'b00, req_addr[31:2]};
    w_err      = w_bad | (w_widx >= 32'(MEM_WORDS));
    w_acc_next = w_err ? S_RESP : !req_we ? S_LOAD : req_funct3 == F3_W ? S_WRITE : S_RMW_RD;
    w_next     = w_accept ? w_acc_next :
                 r_state == S_LOAD   ? S_RESP :
                 r_state == S_RMW_RD ? S_WRITE :
                 r_state == S_WRITE  ? S_RESP : S_IDLE;
  end
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_old      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      if (w_accept) begin
        r_req   <= '{funct3: req_funct3, addr_lo: req_addr[1:0], wdata: req_wdata};
        r_err   <= w_err;
        r_rdata <= '0;
        if (!w_err) r_mem_addr <= w_widx;
      end
      if (r_state == S_LOAD) r_rdata <= w_ldata;
      if (r_state == S_RMW_RD) r_old <= data_mem_read;
      r_state <= w_next;
    end
  end
  assign resp_valid     = r_state == S_RESP;
  assign resp_rdata     = r_rdata;
  assign resp_err       = resp_valid & r_err;
  assign en_w           = r_state == S_WRITE && !rst;
  assign data_mem_addr  = r_mem_addr;
  assign data_mem_write = r_state == S_WRITE ? w_merged : '0;
endmodule
